uart_tx_reporter: RTL and testbench

- Byte-wide UART transmitter (8N1, LSB first) that sends bytes from the game core back to the host PC.
- It is the return path of the RX byte interface (dataRX/WR_RX) the game already consumes.
- A small FIFO decouples game-side event bursts, such as score updates and collision reports, from the serial line rate.
- Sits in the px_clk domain next to the snake core and the UART receiver.

---
 rtl/uart_tx_reporter_if.sv | 12 +
 rtl/uart_tx_reporter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_reporter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_reporter_if.sv
// Byte-write side of the UART return path: game core pushes bytes, transmitter reports line and FIFO status.
interface uart_tx_reporter_if;
  logic [7:0] dataTX;
  logic       WR_TX;
  logic       TX;
  logic       busy;
  logic       full;
  logic       ovf;

  modport master (output dataTX, output WR_TX, input TX, input busy, input full, input ovf);
  modport slave  (input dataTX, input WR_TX, output TX, output busy, output full, output ovf);
endinterface

// File: rtl/uart_tx_reporter.sv
// 8N1 LSB-first UART transmitter with a small byte FIFO, returning game events to the host PC.
module uart_tx_reporter #(
  parameter int unsigned CLK_HZ     = 31500000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                px_clk,
  input  logic                rst,
  uart_tx_reporter_if.slave   bus
);

  localparam int unsigned DIVISOR = CLK_HZ / BAUD;
  localparam int unsigned CW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned NW      = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count, count_nx;
  logic [CW-1:0] baud_cnt, baud_nx;
  logic [2:0]    bit_cnt, bit_nx;
  logic [7:0]    shift, shift_nx;
  logic          tx_q, tx_nx;
  logic          busy_q, full_q, ovf_q;
  logic          bit_end, nonempty, wr_ok, pop;

  assign bit_end  = (baud_cnt == CW'(DIVISOR - 1));
  assign nonempty = (count != '0);
  assign wr_ok    = bus.WR_TX & ~full_q;

  assign bus.TX   = tx_q;
  assign bus.busy = busy_q;
  assign bus.full = full_q;
  assign bus.ovf  = ovf_q;

  // State register
  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (nonempty) state_nx = START;
      START:   if (bit_end) state_nx = DATA;
      DATA:    if (bit_end && bit_cnt == 3'd7) state_nx = STOP;
      STOP:    if (bit_end) state_nx = nonempty ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath next values; a pop loads the head byte and drives the start bit in the same edge
  always_comb begin
    tx_nx    = tx_q;
    shift_nx = shift;
    bit_nx   = bit_cnt;
    baud_nx  = bit_end ? '0 : baud_cnt + CW'(1);
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        baud_nx = '0;
        tx_nx   = 1'b1;
        if (nonempty) begin
          pop      = 1'b1;
          shift_nx = mem[rd_ptr];
          tx_nx    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          tx_nx  = shift[0];
          bit_nx = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            tx_nx = 1'b1;
          end else begin
            shift_nx = {1'b0, shift[7:1]};
            tx_nx    = shift[1];
            bit_nx   = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end && nonempty) begin
          pop      = 1'b1;
          shift_nx = mem[rd_ptr];
          tx_nx    = 1'b0;
        end
      end
      default: tx_nx = 1'b1;
    endcase
  end

  // FIFO occupancy
  always_comb begin
    count_nx = count;
    if (wr_ok && !pop)      count_nx = count + NW'(1);
    else if (!wr_ok && pop) count_nx = count - NW'(1);
  end

  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      count    <= count_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      shift    <= shift_nx;
      tx_q     <= tx_nx;
      busy_q   <= (state_nx != IDLE) | (count_nx != '0);
      full_q   <= (count_nx == NW'(FIFO_DEPTH));
      ovf_q    <= ovf_q | (bus.WR_TX & full_q);
    end
  end

  // Byte storage needs no reset; pointers and count define validity
  always_ff @(posedge px_clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.dataTX;
  end

endmodule

// File: tb/tb_uart_tx_reporter.sv
// Self-checking bench: two transmitters (divisor 16 and default 273) against a frame-schedule model.
module tb_uart_tx_reporter;

  localparam int NB    = 256;
  localparam int DEPTH = 4;

  logic px_clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   low1;
  int   busy1;

  int         div_k [2];
  int         n_b   [2];
  int         acc_a [2][NB];
  int         st_a  [2][NB];
  logic [7:0] dat_a [2][NB];
  bit         ovf_m [2];

  uart_tx_reporter_if bus0 ();
  uart_tx_reporter_if bus1 ();

  uart_tx_reporter #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(4)) dut0 (
    .px_clk (px_clk),
    .rst    (rst),
    .bus    (bus0)
  );

  uart_tx_reporter dut1 (
    .px_clk (px_clk),
    .rst    (rst),
    .bus    (bus1)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      n_b[k]   = 0;
      ovf_m[k] = 1'b0;
    end
  endfunction

  // A byte is accepted if fewer than DEPTH bytes are waiting before edge e; its frame starts
  // one edge after acceptance or right when the previous frame ends, whichever is later.
  function automatic void model_write(input int k, input int e, input logic [7:0] d);
    int occ;
    int s;
    occ = 0;
    for (int i = 0; i < n_b[k]; i++) begin
      if (acc_a[k][i] < e) occ++;
      if (st_a[k][i] < e)  occ--;
    end
    if (occ >= DEPTH) begin
      ovf_m[k] = 1'b1;
    end else if (n_b[k] < NB) begin
      s = e + 1;
      if (n_b[k] > 0 && st_a[k][n_b[k]-1] + 10 * div_k[k] > s)
        s = st_a[k][n_b[k]-1] + 10 * div_k[k];
      acc_a[k][n_b[k]] = e;
      st_a[k][n_b[k]]  = s;
      dat_a[k][n_b[k]] = d;
      n_b[k]++;
    end
  endfunction

  function automatic logic exp_tx(input int k, input int t);
    int o;
    int b;
    for (int i = 0; i < n_b[k]; i++) begin
      if (st_a[k][i] <= t && t < st_a[k][i] + 10 * div_k[k]) begin
        o = t - st_a[k][i];
        b = o / div_k[k];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return dat_a[k][i][b-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int k, input int t);
    for (int i = 0; i < n_b[k]; i++)
      if (acc_a[k][i] <= t && t < st_a[k][i] + 10 * div_k[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_full(input int k, input int t);
    int occ;
    occ = 0;
    for (int i = 0; i < n_b[k]; i++) begin
      if (acc_a[k][i] <= t) occ++;
      if (st_a[k][i] <= t)  occ--;
    end
    return occ == DEPTH;
  endfunction

  task automatic check_all(input int k);
    logic tx, bz, fl, ov;
    if (k == 0) begin
      tx = bus0.TX; bz = bus0.busy; fl = bus0.full; ov = bus0.ovf;
    end else begin
      tx = bus1.TX; bz = bus1.busy; fl = bus1.full; ov = bus1.ovf;
    end
    check($sformatf("tx%0d", k),   32'(tx), 32'(exp_tx(k, cyc)));
    check($sformatf("busy%0d", k), 32'(bz), 32'(exp_busy(k, cyc)));
    check($sformatf("full%0d", k), 32'(fl), 32'(exp_full(k, cyc)));
    check($sformatf("ovf%0d", k),  32'(ov), 32'(ovf_m[k]));
  endtask

  // One clock: drive optional writes, apply them to the model at the edge, compare just after it
  task automatic step(input logic w0, input logic [7:0] d0, input logic w1, input logic [7:0] d1);
    bus0.WR_TX = w0; bus0.dataTX = d0;
    bus1.WR_TX = w1; bus1.dataTX = d1;
    @(posedge px_clk);
    cyc++;
    if (w0) model_write(0, cyc, d0);
    if (w1) model_write(1, cyc, d1);
    #1;
    check_all(0);
    check_all(1);
    if (!bus1.TX)  low1++;
    if (bus1.busy) busy1++;
    bus0.WR_TX = 1'b0; bus0.dataTX = 8'($urandom);
    bus1.WR_TX = 1'b0; bus1.dataTX = 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] b;
    n_cmp = 0; n_bad = 0; cyc = 0; low1 = 0; busy1 = 0;
    div_k[0] = 16; div_k[1] = 273;
    model_reset();
    bus0.WR_TX = 1'b0; bus0.dataTX = 8'h00;
    bus1.WR_TX = 1'b0; bus1.dataTX = 8'h00;

    // Reset state, then a long idle stretch
    rst = 1'b1;
    repeat (3) @(posedge px_clk);
    @(negedge px_clk);
    check("rst_tx0", 32'(bus0.TX), 32'd1);
    check("rst_busy0", 32'(bus0.busy), 32'd0);
    check("rst_full0", 32'(bus0.full), 32'd0);
    check("rst_ovf0", 32'(bus0.ovf), 32'd0);
    rst = 1'b0;
    check("rst_tx1", 32'(bus1.TX), 32'd1);
    check("rst_busy1", 32'(bus1.busy), 32'd0);
    check("rst_full1", 32'(bus1.full), 32'd0);
    check("rst_ovf1", 32'(bus1.ovf), 32'd0);
    idle(1000);

    // Single frame 0x41
    step(1'b1, 8'h41, 1'b0, 8'h00);
    idle(200);

    // Back-to-back 0x55, 0xAA
    step(1'b1, 8'h55, 1'b0, 8'h00);
    step(1'b1, 8'hAA, 1'b0, 8'h00);
    idle(340);

    // Six consecutive writes: fifth fills the FIFO, sixth overflows
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      step(1'b1, b, 1'b0, 8'h00);
      if (i == 4) check("t4_full", 32'(bus0.full), 32'd1);
      if (i == 4) check("t4_ovf_pre", 32'(bus0.ovf), 32'd0);
    end
    check("t4_ovf", 32'(bus0.ovf), 32'd1);
    idle(860);

    // Async reset in data bit 3 with two bytes queued
    step(1'b1, 8'hC3, 1'b0, 8'h00);
    step(1'b1, 8'h5A, 1'b0, 8'h00);
    step(1'b1, 8'h0F, 1'b0, 8'h00);
    idle(68);
    check("t5_pre_tx", 32'(bus0.TX), 32'(exp_tx(0, cyc)));
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_tx", 32'(bus0.TX), 32'd1);
    check("t5_async_busy", 32'(bus0.busy), 32'd0);
    model_reset();
    repeat (2) @(posedge px_clk);
    @(negedge px_clk);
    rst = 1'b0;
    idle(600);

    // Default divisor, all-zero byte
    low1 = 0; busy1 = 0;
    step(1'b0, 8'h00, 1'b1, 8'h00);
    idle(2800);
    check("t6_low", 32'(low1), 32'd2457);
    check("t6_busy", 32'(busy1), 32'd2731);

    // Randomized traffic on both instances
    for (int i = 0; i < 4000; i++)
      step(($urandom % 8) == 0, 8'($urandom), ($urandom % 150) == 0, 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
